// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the sequential Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_Q, CALC, DONE} state_t;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] SEL_NOP = 2'b00;
    localparam logic [1:0] SEL_ADD = 2'b01;
    localparam logic [1:0] SEL_SUB = 2'b10;

    // Radix-2 recoding of the {Q[0], q_1} pair.
    function automatic logic [1:0] booth_sel(input logic q0, input logic q1);
        return ({q0, q1} == 2'b01) ? SEL_ADD : ({q0, q1} == 2'b10) ? SEL_SUB : SEL_NOP;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one Booth add/sub/nop followed by an arithmetic right shift of {A,Q,q_1}
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH:0]   m_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [1:0]     sel;
    logic [WIDTH:0] sum;

    always_comb begin
        sel = booth_sel(q_i[0], q1_i);
        sum = (sel == SEL_ADD) ? a_i + m_i : (sel == SEL_SUB) ? a_i - m_i : a_i;
        {a_o, q_o, q1_o} = {sum[WIDTH], sum, q_i};
    end

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     din,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     m_q, m_d, a_q, a_d, a_s;
    logic [WIDTH-1:0]   q_q, q_d, q_s;
    logic               q1_q, q1_d, q1_s;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i  (a_q),
        .m_i  (m_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .a_o  (a_s),
        .q_o  (q_s),
        .q1_o (q1_s)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (start) begin
                m_d     = {din[WIDTH-1], din};
                state_d = LOAD_Q;
            end
            LOAD_Q: begin
                q_d     = din;
                a_d     = '0;
                q1_d    = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = CALC;
            end
            CALC: begin
                a_d   = a_s;
                q_d   = q_s;
                q1_d  = q1_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    prod_d  = {a_s[WIDTH-1:0], q_s};
                end
            end
            default: state_d = IDLE;
        endcase
        // Status flags are decoded from the next state so they register alongside it.
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed table, corner sequences and random back-to-back products
module tb_booth_seq_mult;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        string          nm;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   din = '0;
    logic           busy, done;
    logic [2*W-1:0] product;

    int             total = 0;
    int             passed = 0;
    logic [2*W-1:0] last_p = '0;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    // Runs cycles 0..W+2 of one operation; cycle 0 is the start cycle.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p,
                      input string nm, input bit inject);
        int dones = 0;
        bit busy_ok = 1'b1;
        bit done_ok = 1'b1;
        for (int c = 0; c <= W + 2; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (inject && c == 5);
            din   = (c == 0) ? a : (c == 1) ? b : W'($urandom);
            @(negedge clk);
            if (done) dones++;
            if (busy !== (c >= 1)) busy_ok = 1'b0;
            if (done !== (c == W + 2)) done_ok = 1'b0;
            if (c == 1) chk({nm, " held"}, 64'(product), 64'(last_p));
            if (c == W + 2) chk({nm, " product"}, 64'(product), 64'(p));
        end
        start = 1'b0;
        chk({nm, " busy"}, 64'(busy_ok), 64'd1);
        chk({nm, " done_cycle"}, 64'(done_ok), 64'd1);
        chk({nm, " done_count"}, 64'(dones), 64'd1);
        last_p = p;
    endtask

    initial begin
        vec_t vecs[8];
        int   nd;
        vecs[0] = '{16'h0007, 16'hFFFD, 32'hFFFFFFEB, "7x-3"};
        vecs[1] = '{16'h8000, 16'h8000, 32'h40000000, "min_x_min"};
        vecs[2] = '{16'h0000, 16'h1234, 32'h00000000, "zero"};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 32'h00000001, "m1_x_m1"};
        vecs[4] = '{16'h7FFF, 16'h8000, 32'hC0008000, "max_x_min"};
        vecs[5] = '{16'h0005, 16'h0005, 32'h00000019, "5x5"};
        vecs[6] = '{16'hFFFE, 16'h0003, 32'hFFFFFFFA, "-2x3"};
        vecs[7] = '{16'h1234, 16'h0010, 32'h00012340, "shift"};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset product", 64'(product), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nm, 1'b0);

        // start pulsed mid-CALC must be ignored; the next op starts in cycle 19
        op(16'h0007, 16'hFFFD, 32'hFFFFFFEB, "ignore_start", 1'b1);
        op(16'h0100, 16'hFF00, 32'hFFFF0000, "after_ignore", 1'b0);

        // abort with reset in cycle 10
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            din   = (c == 0) ? 16'h1234 : 16'h0042;
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort product", 64'(product), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort quiet", 64'(nd), 64'd0);
        last_p = '0;
        op(16'h0005, 16'h0005, 32'h00000019, "post_abort", 1'b0);

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] a, b;
            int e;
            a = W'($urandom);
            b = W'($urandom);
            e = int'($signed(a)) * int'($signed(b));
            op(a, b, 32'(e), $sformatf("rnd%0d", k), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
